// File: rtl/wshb_sdram_arbiter_if.sv
// Wishbone bus bundle shared by the SDRAM arbiter, its requesters and the SDRAM slave.
// Master drives the request side; slave drives data-back and the ack/err/rty/stall returns.
interface wshb_if #(
    parameter int DATA_BYTES = 4
) ();
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [31:0]             adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [DATA_BYTES-1:0]   sel;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic                    stall;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty, stall
    );
endinterface

// File: rtl/wshb_sdram_arbiter.sv
// Two-requester Wishbone arbiter in front of the SDRAM slave; ownership is held for a whole cyc.
// Optional statistics outputs (ack counters, worst wait) are built when ARB_STATS_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | no owner, master side driven to zero
// ST_OWN0  | requester 0 (video reader) owns the SDRAM port
// ST_OWN1  | requester 1 (writer/host) owns the SDRAM port
module wshb_sdram_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int DATA_BYTES = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    wshb_if.slave       wshb_ifs0,
    wshb_if.slave       wshb_ifs1,
    wshb_if.master      wshb_ifm,
    output logic [1:0]  grant
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] ack_cnt0,
    output logic [31:0] ack_cnt1,
    output logic [15:0] wait_max
`endif
);

    localparam int DATA_W = 8 * DATA_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // A tie is only possible from idle; an owner's exit can only hand over to the other side.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (wshb_ifs0.cyc && wshb_ifs1.cyc) begin
                    state_d = ((FIXED_PRIO != 0) || last_q) ? ST_OWN0 : ST_OWN1;
                end else if (wshb_ifs0.cyc) begin
                    state_d = ST_OWN0;
                end else if (wshb_ifs1.cyc) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!wshb_ifs0.cyc) begin
                    last_d  = 1'b0;
                    state_d = wshb_ifs1.cyc ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!wshb_ifs1.cyc) begin
                    last_d  = 1'b1;
                    state_d = wshb_ifs0.cyc ? ST_OWN0 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        grant            = 2'b00;
        wshb_ifm.cyc     = 1'b0;
        wshb_ifm.stb     = 1'b0;
        wshb_ifm.we      = 1'b0;
        wshb_ifm.adr     = 32'h0;
        wshb_ifm.dat_ms  = {DATA_W{1'b0}};
        wshb_ifm.sel     = {DATA_BYTES{1'b0}};
        wshb_ifm.cti     = 3'b000;
        wshb_ifm.bte     = 2'b00;
        wshb_ifs0.ack    = 1'b0;
        wshb_ifs0.err    = 1'b0;
        wshb_ifs0.rty    = 1'b0;
        wshb_ifs0.stall  = 1'b1;
        wshb_ifs1.ack    = 1'b0;
        wshb_ifs1.err    = 1'b0;
        wshb_ifs1.rty    = 1'b0;
        wshb_ifs1.stall  = 1'b1;
        case (state_q)
            ST_OWN0: begin
                grant           = 2'b01;
                wshb_ifm.cyc    = wshb_ifs0.cyc;
                wshb_ifm.stb    = wshb_ifs0.stb;
                wshb_ifm.we     = wshb_ifs0.we;
                wshb_ifm.adr    = wshb_ifs0.adr;
                wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
                wshb_ifm.sel    = wshb_ifs0.sel;
                wshb_ifm.cti    = wshb_ifs0.cti;
                wshb_ifm.bte    = wshb_ifs0.bte;
                wshb_ifs0.ack   = wshb_ifm.ack;
                wshb_ifs0.err   = wshb_ifm.err;
                wshb_ifs0.rty   = wshb_ifm.rty;
                wshb_ifs0.stall = wshb_ifm.stall;
            end
            ST_OWN1: begin
                grant           = 2'b10;
                wshb_ifm.cyc    = wshb_ifs1.cyc;
                wshb_ifm.stb    = wshb_ifs1.stb;
                wshb_ifm.we     = wshb_ifs1.we;
                wshb_ifm.adr    = wshb_ifs1.adr;
                wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
                wshb_ifm.sel    = wshb_ifs1.sel;
                wshb_ifm.cti    = wshb_ifs1.cti;
                wshb_ifm.bte    = wshb_ifs1.bte;
                wshb_ifs1.ack   = wshb_ifm.ack;
                wshb_ifs1.err   = wshb_ifm.err;
                wshb_ifs1.rty   = wshb_ifm.rty;
                wshb_ifs1.stall = wshb_ifm.stall;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; the non-owner never sees ack so it never consumes it.
    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

`ifdef ARB_STATS_EN
    logic [31:0] ack_cnt0_q, ack_cnt0_d;
    logic [31:0] ack_cnt1_q, ack_cnt1_d;
    logic [15:0] wait0_q, wait0_d;
    logic [15:0] wait1_q, wait1_d;
    logic [15:0] wait_max_q, wait_max_d;

    always_comb begin
        ack_cnt0_d = ack_cnt0_q;
        ack_cnt1_d = ack_cnt1_q;
        wait0_d    = 16'd0;
        wait1_d    = 16'd0;
        wait_max_d = wait_max_q;
        if ((state_q == ST_OWN0) && wshb_ifm.ack) begin
            ack_cnt0_d = ack_cnt0_q + 32'd1;
        end
        if ((state_q == ST_OWN1) && wshb_ifm.ack) begin
            ack_cnt1_d = ack_cnt1_q + 32'd1;
        end
        if (wshb_ifs0.cyc && (state_q != ST_OWN0)) begin
            wait0_d = (wait0_q == 16'hFFFF) ? wait0_q : wait0_q + 16'd1;
        end
        if (wshb_ifs1.cyc && (state_q != ST_OWN1)) begin
            wait1_d = (wait1_q == 16'hFFFF) ? wait1_q : wait1_q + 16'd1;
        end
        if (wait0_d > wait_max_d) begin
            wait_max_d = wait0_d;
        end
        if (wait1_d > wait_max_d) begin
            wait_max_d = wait1_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ack_cnt0_q <= 32'd0;
            ack_cnt1_q <= 32'd0;
            wait0_q    <= 16'd0;
            wait1_q    <= 16'd0;
            wait_max_q <= 16'd0;
        end else begin
            ack_cnt0_q <= ack_cnt0_d;
            ack_cnt1_q <= ack_cnt1_d;
            wait0_q    <= wait0_d;
            wait1_q    <= wait1_d;
            wait_max_q <= wait_max_d;
        end
    end

    assign ack_cnt0 = ack_cnt0_q;
    assign ack_cnt1 = ack_cnt1_q;
    assign wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Bench for wshb_sdram_arbiter: round-robin and fixed-priority instances side by side, each with
// random requesters, a random SDRAM slave and a cycle-level ownership model.
module tb_wshb_sdram_arbiter;

    localparam int DB = 4;
    localparam int BW = 40 + 9 * DB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       go    = 1'b0;
    logic [1:0] mcyc_w;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        wshb_if #(.DATA_BYTES(DB)) rq [2] ();
        wshb_if #(.DATA_BYTES(DB)) m ();
        logic [1:0] grant;
`ifdef ARB_STATS_EN
        logic [31:0] ack_cnt0, ack_cnt1;
        logic [15:0] wait_max;
`endif

        wshb_sdram_arbiter #(.FIXED_PRIO(g), .DATA_BYTES(DB)) dut (
            .sys_clk   (clk),
            .sys_rst_n (rst_n),
            .wshb_ifs0 (rq[0]),
            .wshb_ifs1 (rq[1]),
            .wshb_ifm  (m),
            .grant     (grant)
`ifdef ARB_STATS_EN
            ,
            .ack_cnt0  (ack_cnt0),
            .ack_cnt1  (ack_cnt1),
            .wait_max  (wait_max)
`endif
        );

        assign mcyc_w[g] = m.cyc;

        // SDRAM slave: classic single-cycle ack with random wait states and random stall/err noise.
        initial begin : slave
            m.ack = 1'b0; m.err = 1'b0; m.rty = 1'b0; m.stall = 1'b0; m.dat_sm = '0;
            forever begin
                @(posedge clk); #2;
                m.ack    = rst_n && m.cyc && m.stb && !m.ack && ($urandom_range(0, 2) != 0);
                m.err    = !m.cyc && ($urandom_range(0, 7) == 0);
                m.rty    = !m.cyc && ($urandom_range(0, 7) == 0);
                m.stall  = ($urandom_range(0, 3) == 0);
                m.dat_sm = $urandom;
            end
        end

        for (genvar r = 0; r < 2; r++) begin : g_req
            initial begin : drv
                int  beats, got, idle, waited;
                logic blip, a;
                rq[r].cyc = 1'b0; rq[r].stb = 1'b0; rq[r].we = 1'b0; rq[r].adr = '0;
                rq[r].dat_ms = '0; rq[r].sel = '0; rq[r].cti = '0; rq[r].bte = '0;
                wait (go);
                @(posedge clk); #1;
                while (go) begin
                    idle = $urandom_range(0, 3);
                    repeat (idle) begin @(posedge clk); #1; end
                    blip  = ($urandom_range(0, 7) == 0);
                    beats = blip ? 0 : $urandom_range(1, 8);
                    rq[r].cyc    = 1'b1;
                    rq[r].stb    = !blip;
                    rq[r].we     = 1'($urandom_range(0, 1));
                    rq[r].adr    = $urandom & 32'hFFFF_FFFC;
                    rq[r].dat_ms = $urandom;
                    rq[r].sel    = 4'hF;
                    rq[r].cti    = (beats > 1) ? 3'b010 : 3'b000;
                    got = 0; waited = 0;
                    if (blip) begin
                        @(posedge clk); #1;
                    end
                    while (got < beats && rst_n && waited < 300) begin
                        @(negedge clk); a = rq[r].ack;
                        @(posedge clk); #1;
                        waited++;
                        if (a) begin
                            got++;
                            rq[r].adr    = rq[r].adr + 32'(DB);
                            rq[r].dat_ms = $urandom;
                        end
                    end
                    if (rst_n && got < beats) chk($sformatf("i%0d.r%0d.timeout", g, r), 128'(got), 128'(beats));
                    rq[r].cyc = 1'b0; rq[r].stb = 1'b0; rq[r].cti = 3'b000;
                    @(posedge clk); #1;
                end
            end
        end

        // Ownership model: owner -1/0/1 and last-served, advanced once per cycle from sampled cyc.
        initial begin : model
            int          own;
            logic        lst;
            logic        c0, c1;
            logic [1:0]  eg;
            logic [BW-1:0] b0, b1, bm, bexp;
            logic [3:0]  mr;
            int          nack [2];
            int          run [2];
            int          wmax;
            own = -1; lst = 1'b1; nack[0] = 0; nack[1] = 0; run[0] = 0; run[1] = 0; wmax = 0;
            forever begin
                @(negedge clk);
                mr = {m.ack, m.err, m.rty, m.stall};
                bm = {m.cyc, m.stb, m.we, m.adr, m.dat_ms, m.sel, m.cti, m.bte};
                if (!rst_n) begin
                    own = -1; lst = 1'b1; nack[0] = 0; nack[1] = 0; run[0] = 0; run[1] = 0; wmax = 0;
                    chk($sformatf("i%0d.rst_grant", g), 128'(grant), 128'(2'b00));
                    chk($sformatf("i%0d.rst_master", g), 128'(bm), 128'(0));
                    chk($sformatf("i%0d.rst_ret0", g), 128'({rq[0].ack, rq[0].err, rq[0].rty, rq[0].stall}), 128'(4'b0001));
                    chk($sformatf("i%0d.rst_ret1", g), 128'({rq[1].ack, rq[1].err, rq[1].rty, rq[1].stall}), 128'(4'b0001));
`ifdef ARB_STATS_EN
                    chk($sformatf("i%0d.rst_stats", g), 128'({ack_cnt0, ack_cnt1, wait_max}), 128'(0));
`endif
                end else begin
                    c0 = rq[0].cyc; c1 = rq[1].cyc;
                    b0 = {rq[0].cyc, rq[0].stb, rq[0].we, rq[0].adr, rq[0].dat_ms, rq[0].sel, rq[0].cti, rq[0].bte};
                    b1 = {rq[1].cyc, rq[1].stb, rq[1].we, rq[1].adr, rq[1].dat_ms, rq[1].sel, rq[1].cti, rq[1].bte};
                    eg   = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
                    bexp = (own == 0) ? b0 : (own == 1) ? b1 : '0;
                    chk($sformatf("i%0d.grant", g), 128'(grant), 128'(eg));
                    chk($sformatf("i%0d.master", g), 128'(bm), 128'(bexp));
                    chk($sformatf("i%0d.ret0", g), 128'({rq[0].ack, rq[0].err, rq[0].rty, rq[0].stall}),
                        128'((own == 0) ? mr : 4'b0001));
                    chk($sformatf("i%0d.ret1", g), 128'({rq[1].ack, rq[1].err, rq[1].rty, rq[1].stall}),
                        128'((own == 1) ? mr : 4'b0001));
                    chk($sformatf("i%0d.dat_sm", g), 128'({rq[0].dat_sm, rq[1].dat_sm}), 128'({m.dat_sm, m.dat_sm}));
`ifdef ARB_STATS_EN
                    chk($sformatf("i%0d.ack_cnt", g), 128'({ack_cnt0, ack_cnt1}), 128'({32'(nack[0]), 32'(nack[1])}));
                    chk($sformatf("i%0d.wait_max", g), 128'(wait_max), 128'(wmax));
`endif
                    if (own >= 0 && m.ack) nack[own]++;
                    for (int k = 0; k < 2; k++) begin
                        if (((k == 0) ? c0 : c1) && own != k) run[k] = (run[k] < 65535) ? run[k] + 1 : 65535;
                        else run[k] = 0;
                        if (run[k] > wmax) wmax = run[k];
                    end
                    // Exit or arbitration only when the current owner is not holding cyc.
                    if (!(own == 0 && c0) && !(own == 1 && c1)) begin
                        if (own >= 0) lst = (own == 1);
                        if (c0 && c1)  own = (g == 1) ? 0 : (lst ? 0 : 1);
                        else if (c0)   own = 0;
                        else if (c1)   own = 1;
                        else           own = -1;
                    end
                end
            end
        end

        initial begin : rst_watch
            forever begin
                @(negedge rst_n); #1;
                chk($sformatf("i%0d.async_cyc", g), 128'(m.cyc), 128'(0));
                chk($sformatf("i%0d.async_grant", g), 128'(grant), 128'(2'b00));
                chk($sformatf("i%0d.async_ack", g), 128'({rq[0].ack, rq[1].ack}), 128'(2'b00));
            end
        end
    end

    initial begin : main
        int n;
        #23 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        go = 1'b1;
        repeat (3000) @(posedge clk);
        n = 0;
        while (!(mcyc_w[0] && mcyc_w[1]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("burst_found", 128'(n < 200), 128'(1));
        @(posedge clk); #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3000) @(posedge clk);
        go = 1'b0;
        repeat (400) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wshb_sdram_arbiter.md
Name: wshb_sdram_arbiter

Overview:
- Two-requester Wishbone arbiter sharing the single SDRAM slave port between the video-stream reader (requester 0) and a pixel writer/host path (requester 1).
- Sits between the requesters and the wshb_if_sdram slave of hw_support; all logic runs on sys_clk at 100 MHz.
- Ownership is registered and held for a whole Wishbone cycle (cyc high), so bursts are never split.
- Tie-breaking is round-robin or fixed priority, selected by parameter.

Parameters:
- FIXED_PRIO, 0: when 1, requester 0 always wins ties; when 0, ties are resolved round-robin.
- DATA_BYTES, 4: Wishbone data width in bytes, passed to all wshb_if ports.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  system reset.
- wshb_ifs0  wshb_if.slave  DATA_BYTES  requester 0 (video reader).
- wshb_ifs1  wshb_if.slave  DATA_BYTES  requester 1 (writer).
- wshb_ifm  wshb_if.master  DATA_BYTES  to the SDRAM slave.
- grant  out  2  one-hot current owner (00 = idle), for LED/debug use.

Interface decision: one clock, sys_clk; reset sys_rst_n is asynchronous and active-low.

Behaviour:
- State machine with states IDLE, OWN0 and OWN1, plus a 1-bit register last (last served requester). Grant is decoded from the state.
- Reset (asynchronous, sys_rst_n=0):
  - state=IDLE, last=1, so requester 0 wins the first tie.
  - grant=00.
  - wshb_ifm.cyc/stb/we=0; adr, dat_ms, sel, cti and bte driven with 0.
  - Both requesters see ack/err/rty=0 and stall=1.
  - Reset asserted mid-transfer drops ownership immediately, with no completion.
- Transitions out of IDLE:
  - only ifs0.cyc → OWN0; only ifs1.cyc → OWN1.
  - both requesting: FIXED_PRIO=1 → OWN0; otherwise → the requester that is not last.
  - neither requesting → stay in IDLE.
- Transitions out of OWNx:
  - stay while ifsx.cyc=1.
  - when ifsx.cyc=0 is sampled, go to OWNy if the other requester's cyc=1, else to IDLE.
  - the last register updates to x on every exit from OWNx.
- Latency:
  - 1 cycle from cyc rising in IDLE to the grant becoming visible.
  - Direct OWNx→OWNy handover costs 1 cycle; no idle cycle is inserted.
- Master-side outputs are a combinational mux driven by the registered state:
  - in OWNx, cyc/stb/we/adr/dat_ms/sel/cti/bte come from ifsx.
  - in IDLE, all are 0.
- Owner's return signals: ack/err/rty/stall are forwarded from wshb_ifm.
- Non-owner's return signals: ack/err/rty=0, stall=1.
- dat_sm is broadcast to both requesters; this is valid because ack gating protects the non-owner.
- The arbiter never asserts ack itself and never drops cyc on its own while a transfer is owned.
- A requester whose cyc rises in the same cycle the owner's cyc falls is granted on the next edge, per the exit rule.
- A requester that raises and lowers cyc while not owner is never granted; nothing is latched.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds three outputs:
  - ack_cnt0 (32 bits): wrapping count of acks delivered to requester 0.
  - ack_cnt1 (32 bits): wrapping count of acks delivered to requester 1.
  - wait_max (16 bits): longest run of cycles a requester held cyc=1 without owning the bus; saturates at 16'hFFFF.
- All three reset to 0 on sys_rst_n=0.
- When undefined, these ports and their registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset release, no requests → grant=00, wshb_ifm.cyc=0 for 20 cycles; both stalls=1.
- ifs0 single read at adr 32'h100 with a slave ack after 3 cycles → grant=01 one cycle after cyc; ifs0 sees ack and the slave's data; ifs1 sees ack=0 throughout.
- Both cyc rise together, FIXED_PRIO=0, repeated 4 times (each cycle = 1 transfer) → owners 0,1,0,1; each handover inserts exactly 1 cycle.
- Same stimulus with FIXED_PRIO=1 → requester 0 wins every tie; requester 1 is granted only when cyc0 is low at arbitration.
- ifs1 8-beat burst (cti=3'b010); ifs0 requests at beat 2 → no switch until ifs1.cyc falls, then OWN0 on the next edge; all 8 acks reach ifs1 only.
- sys_rst_n pulsed low mid-burst → wshb_ifm.cyc=0 asynchronously; grant=00; with ARB_STATS_EN, the counters read 0.
